// File: rtl/am_insert_tx_if.sv
// Block stream between the scrambler/distributor and the AM inserter, plus the
// inserter's output toward the gearbox.
interface am_insert_tx_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66
);
    logic                        valid_i;
    logic [LANE_N*BLOCK_W-1:0]   data_i;
    logic                        ready_o;
    logic                        valid_o;
    logic                        am_v_o;
    logic [LANE_N*BLOCK_W-1:0]   data_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, am_v_o, data_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, am_v_o, data_o
    );
endinterface

// File: rtl/am_insert_tx.sv
// 40GBASE-R transmit alignment marker inserter: one marker on all four lanes
// every AM_GAP_N accepted blocks, with per-lane BIP3/BIP7 parity fields.
module am_insert_tx #(
    parameter int LANE_N   = 4,
    parameter int BLOCK_W  = 66,
    parameter int AM_GAP_N = 16383
) (
    input  logic           clk,
    input  logic           nreset,
    am_insert_tx_if.slave  bus
);
    localparam int CNT_W = $clog2(AM_GAP_N + 1);
    localparam int DW    = LANE_N * BLOCK_W;

    // Fixed marker bytes per lane, packed as {M6, M5, M4, M2, M1, M0}.
    function automatic logic [47:0] am_const(input int lane);
        case (lane)
            0:       return 48'hb8_89_6f_47_76_90;
            1:       return 48'h19_3b_0f_e6_c4_f0;
            2:       return 48'h64_9a_3a_9b_65_c5;
            3:       return 48'hc2_86_5d_3d_79_a2;
            default: return 48'h0;
        endcase
    endfunction

    function automatic logic [7:0] blk_par(input logic [65:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p ^= b[8*k +: 8];
        end
        p[3] ^= b[65];
        p[4] ^= b[64];
        return p;
    endfunction

    function automatic logic [65:0] am_block(input int lane, input logic [7:0] bip);
        logic [47:0] c;
        c = am_const(lane);
        return {2'b10, ~bip, c[47:24], bip, c[23:0]};
    endfunction

    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [LANE_N-1:0][7:0]  bip_q,   bip_d;
    logic                    valid_q, valid_d;
    logic                    am_v_q,  am_v_d;
    logic [DW-1:0]           data_q,  data_d;

    // cnt == 0 marks a marker slot; it is purely registered so ready has no
    // combinational dependence on valid_i.
    assign bus.ready_o = (cnt_q != '0);
    assign bus.valid_o = valid_q;
    assign bus.am_v_o  = am_v_q;
    assign bus.data_o  = data_q;

    always_comb begin
        logic [65:0] mk;
        mk      = '0;
        cnt_d   = cnt_q;
        bip_d   = bip_q;
        valid_d = 1'b0;
        am_v_d  = 1'b0;
        data_d  = data_q;
        if (cnt_q == '0) begin
            valid_d = 1'b1;
            am_v_d  = 1'b1;
            cnt_d   = CNT_W'(AM_GAP_N);
            for (int l = 0; l < LANE_N; l++) begin
                mk                          = am_block(l, bip_q[l]);
                data_d[l*BLOCK_W +: BLOCK_W] = mk;
                // The new parity window starts with the marker just sent.
                bip_d[l]                    = blk_par(mk);
            end
        end else if (bus.valid_i) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            data_d  = bus.data_i;
            for (int l = 0; l < LANE_N; l++) begin
                bip_d[l] = bip_q[l] ^ blk_par(bus.data_i[l*BLOCK_W +: BLOCK_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q   <= '0;
            bip_q   <= '0;
            valid_q <= 1'b0;
            am_v_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bip_q   <= bip_d;
            valid_q <= valid_d;
            am_v_q  <= am_v_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_am_insert_tx.sv
// Randomized bench for am_insert_tx against a queue-based model of the
// marker schedule and parity windows.
module tb_am_insert_tx;
    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int GAP     = 4;
    localparam int DW      = LANE_N * BLOCK_W;

    localparam logic [7:0] AM_TAB [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6f, 8'h89, 8'hb8},
        '{8'hf0, 8'hc4, 8'he6, 8'h0f, 8'h3b, 8'h19},
        '{8'hc5, 8'h65, 8'h9b, 8'h3a, 8'h9a, 8'h64},
        '{8'ha2, 8'h79, 8'h3d, 8'h5d, 8'h86, 8'hc2}
    };
    localparam logic [65:0] L0_RST = {2'b10, 64'hffb8896f00477690};
    localparam logic [65:0] L3_RST = {2'b10, 64'hffc2865d003d79a2};

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    am_insert_tx_if #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W)) bus();

    am_insert_tx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_GAP_N(GAP)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: blocks in each lane's current parity window, data blocks since last marker.
    logic [65:0]     win [LANE_N][$];
    int              m_since;
    bit              m_fresh;
    logic [DW-1:0]   last_d;
    logic [DW+2:0]   obs_vec, exp_vec;   // {ready, valid, am_v, data}
    bit              exp_acc;

    function automatic logic [7:0] ref_par(input logic [65:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) p[i % 8] ^= b[i];
        p[3] ^= b[65];
        p[4] ^= b[64];
        return p;
    endfunction

    function automatic logic [65:0] ref_marker(input int l, input logic [7:0] bip);
        logic [7:0]  by [8];
        logic [65:0] m;
        by[0] = AM_TAB[l][0]; by[1] = AM_TAB[l][1]; by[2] = AM_TAB[l][2];
        by[3] = bip;
        by[4] = AM_TAB[l][3]; by[5] = AM_TAB[l][4]; by[6] = AM_TAB[l][5];
        by[7] = ~bip;
        m[65:64] = 2'b10;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = by[k];
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd_blk();
        logic [95:0]   r;
        logic [DW-1:0] d;
        for (int l = 0; l < LANE_N; l++) begin
            r = {$urandom, $urandom, $urandom};
            d[l*BLOCK_W +: BLOCK_W] = r[65:0];
        end
        return d;
    endfunction

    function automatic logic [DW-1:0] num_blk(input int n);
        logic [DW-1:0] d;
        for (int l = 0; l < LANE_N; l++)
            d[l*BLOCK_W +: BLOCK_W] = {2'b01, 32'(n), 24'h0, 8'(l)};
        return d;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANE_N; l++) win[l].delete();
        m_since = 0;
        m_fresh = 1'b1;
        last_d  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset      = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
    endtask

    // One cycle: drive, predict, sample ready before the edge and outputs after it.
    task automatic step(input bit v, input logic [DW-1:0] d);
        bit            due, ev, eam;
        logic [DW-1:0] ed;
        logic [7:0]    bip;
        logic [65:0]   mk;
        @(negedge clk);
        bus.valid_i = v;
        bus.data_i  = d;
        due = m_fresh || (m_since == GAP);
        ed = last_d; ev = 1'b0; eam = 1'b0; exp_acc = 1'b0;
        if (due) begin
            for (int l = 0; l < LANE_N; l++) begin
                bip = '0;
                for (int j = 0; j < win[l].size(); j++) bip ^= ref_par(win[l][j]);
                mk = ref_marker(l, bip);
                ed[l*BLOCK_W +: BLOCK_W] = mk;
                win[l].delete();
                win[l].push_back(mk);
            end
            m_since = 0; m_fresh = 1'b0; ev = 1'b1; eam = 1'b1;
        end else if (v) begin
            ed = d;
            for (int l = 0; l < LANE_N; l++) win[l].push_back(d[l*BLOCK_W +: BLOCK_W]);
            m_since++; ev = 1'b1; exp_acc = 1'b1;
        end
        exp_vec = {!due, ev, eam, ed};
        obs_vec[DW+2] = bus.ready_o;
        @(posedge clk);
        #1;
        obs_vec[DW+1:0] = {bus.valid_o, bus.am_v_o, bus.data_o};
        last_d = ed;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.ready_o, bus.valid_o, bus.am_v_o, bus.data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0",
                     {bus.ready_o, bus.valid_o, bus.am_v_o, bus.data_o});
        end
        nreset = 1'b1;
        step(1'b0, '0);
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++; $display("FAIL reset_marker got %h expected %h", obs_vec, exp_vec);
        end
        checks++;
        if (obs_vec[DW+2] !== 1'b0) begin
            errors++; $display("FAIL release_ready got %b expected 0", obs_vec[DW+2]);
        end
        checks++;
        if (obs_vec[65:0] !== L0_RST) begin
            errors++; $display("FAIL reset_lane0 got %h expected %h", obs_vec[65:0], L0_RST);
        end
        checks++;
        if (obs_vec[DW-1 -: 66] !== L3_RST) begin
            errors++; $display("FAIL reset_lane3 got %h expected %h", obs_vec[DW-1 -: 66], L3_RST);
        end
        step(1'b0, '0);
        checks++;
        if (obs_vec[DW+2] !== 1'b1) begin
            errors++; $display("FAIL ready_after_marker got %b expected 1", obs_vec[DW+2]);
        end
    endtask

    task automatic test_continuous();
        int nxt, ndata;
        logic [DW-1:0] lastdata;
        do_reset();
        nreset = 1'b1;
        nxt = 0; ndata = 0; lastdata = '0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, num_blk(nxt));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL cont_cycle%0d got %h expected %h", i, obs_vec, exp_vec);
            end
            checks++;
            if (obs_vec[DW] !== ((i % 5) == 0)) begin
                errors++; $display("FAIL cont_marker_slot%0d got %b expected %b", i, obs_vec[DW], (i % 5) == 0);
            end
            if (exp_acc) nxt++;
            if (obs_vec[DW+1] && !obs_vec[DW]) begin
                ndata++;
                lastdata = obs_vec[DW-1:0];
            end
        end
        checks++;
        if (ndata != 12 || lastdata !== num_blk(11)) begin
            errors++; $display("FAIL cont_count got %0d blocks last %h expected 12 last %h",
                               ndata, lastdata, num_blk(11));
        end
    endtask

    task automatic test_bip();
        logic [DW-1:0] zero;
        zero = {LANE_N{2'b01, 64'h0}};
        do_reset();
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, zero);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bip_cycle%0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        checks++;
        if (obs_vec[DW] !== 1'b1 || obs_vec[31:24] !== 8'h08 || obs_vec[63:56] !== 8'hf7) begin
            errors++; $display("FAIL bip_lane0 got am %b bip3 %h bip7 %h expected am 1 bip3 08 bip7 f7",
                               obs_vec[DW], obs_vec[31:24], obs_vec[63:56]);
        end
    endtask

    task automatic test_bubbles();
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        do_reset();
        nreset = 1'b1;
        step(1'b0, '0);
        for (int i = 0; i < 7; i++) begin
            step(pat[i], rnd_blk());
            checks++;
            if (obs_vec !== exp_vec || obs_vec[DW+1] !== pat[i]) begin
                errors++; $display("FAIL bubble_cycle%0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
        step(1'b1, rnd_blk());
        checks++;
        if (obs_vec[DW] !== 1'b1 || obs_vec !== exp_vec) begin
            errors++; $display("FAIL bubble_marker got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_held();
        logic [DW-1:0] x;
        do_reset();
        nreset = 1'b1;
        step(1'b0, '0);
        repeat (4) step(1'b1, rnd_blk());
        x = rnd_blk();
        step(1'b1, x);
        checks++;
        if (obs_vec[DW+2] !== 1'b0 || obs_vec[DW] !== 1'b1) begin
            errors++; $display("FAIL held_marker got ready %b am %b expected ready 0 am 1",
                               obs_vec[DW+2], obs_vec[DW]);
        end
        step(1'b1, x);
        checks++;
        if (obs_vec[DW-1:0] !== x || obs_vec[DW+1:DW] !== 2'b10) begin
            errors++; $display("FAIL held_data got %h expected %h", obs_vec[DW-1:0], x);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_blk());
            checks++;
            if (obs_vec !== exp_vec || obs_vec[DW] !== (i == 3)) begin
                errors++; $display("FAIL held_after%0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] cur;
        do_reset();
        nreset = 1'b1;
        step(1'b0, '0);
        repeat (2) step(1'b1, rnd_blk());
        do_reset();
        nreset = 1'b1;
        cur = rnd_blk();
        step(1'b1, cur);
        for (int l = 0; l < LANE_N; l++) begin
            checks++;
            if (obs_vec[DW] !== 1'b1 || obs_vec[l*66+24 +: 8] !== 8'h00 || obs_vec[l*66+56 +: 8] !== 8'hff) begin
                errors++; $display("FAIL midreset_lane%0d got am %b bip3 %h bip7 %h expected 1 00 ff",
                                   l, obs_vec[DW], obs_vec[l*66+24 +: 8], obs_vec[l*66+56 +: 8]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, cur);
            if (exp_acc) cur = rnd_blk();
            checks++;
            if (obs_vec !== exp_vec || obs_vec[DW] !== (i == 4)) begin
                errors++; $display("FAIL midreset_slot%0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] cur;
        bit v, pend;
        do_reset();
        nreset = 1'b1;
        cur = rnd_blk();
        pend = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v = pend ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(v, cur);
            pend = v && !exp_acc;
            if (exp_acc) cur = rnd_blk();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL random_cycle%0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        model_reset();
        test_reset();
        test_continuous();
        test_bip();
        test_bubbles();
        test_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
